conv_row_sched: RTL and testbench

- Row/column sequencer for one line-buffer FIFO stage of a convolution group.
- On each row-start pulse it waits a fixed pad delay, then walks SIZE+2*PAD column slots of CHANNEL beats each.
- For real columns it issues FIFO read requests and a data-valid delayed by the FIFO read latency. For padding columns it issues zero-insert beats.
- Instances chain row to row: o_hsync of one drives i_hsync of the next.

---
 rtl/conv_sched_pkg.sv | 18 +
 rtl/sched_cnt.sv | 28 ++
 rtl/conv_row_sched.sv | 187 ++++++++++++++++++
 tb/tb_conv_row_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the convolution row scheduler.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SLOT,
        ST_GAP
    } sched_state_e;

    localparam int FIFO_RD_LAT = 1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sched_cnt.sv
// Terminal-count down-counter with synchronous clear and load; holds at zero.
module sched_cnt #(
    parameter int W = 4
) (
    input  logic         i_sclk,
    input  logic         i_rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/conv_row_sched.sv
// Row/column sequencer for one line-buffer FIFO stage: pad wait, then
// SIZE+2*PAD column slots of CHANNEL beats, padding columns as zero-insert beats.
module conv_row_sched
    import conv_sched_pkg::*;
#(
    parameter int SIZE    = 28,
    parameter int CHANNEL = 128,
    parameter int PADWAIT = 21,
    parameter int GAP     = 0,
    parameter int PAD     = 1
) (
    input  logic                       i_sclk,
    input  logic                       i_rst,
    input  logic                       i_vsync,
    input  logic                       i_hsync,
    output logic                       o_rdreq,
    output logic                       o_valid,
    output logic                       o_reuse,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_row_done,
    output logic                       o_frame_done,
    output logic [cnt_width(SIZE)-1:0] o_row,
    output logic                       o_busy,
    output logic                       o_overrun
);

    localparam int NCOL = SIZE + 2 * PAD;
    localparam int WW   = cnt_width((PADWAIT > 0) ? PADWAIT : 1);
    localparam int BW   = cnt_width(CHANNEL);
    localparam int GW   = cnt_width((GAP > 0) ? GAP : 1);
    localparam int CW   = cnt_width(NCOL);
    localparam int RW   = cnt_width(SIZE);

    localparam logic [WW-1:0] WAIT_LD  = WW'((PADWAIT > 0) ? PADWAIT - 1 : 0);
    localparam logic [BW-1:0] BEAT_LD  = BW'(CHANNEL - 1);
    localparam logic [GW-1:0] GAP_LD   = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] COL_LD   = CW'(NCOL - 1);
    localparam logic [CW-1:0] PAD_LO   = CW'(PAD);
    localparam logic [CW-1:0] PAD_HI   = CW'(SIZE + PAD);
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);

    sched_state_e state, state_nx;

    logic          wait_ld, wait_dec, wait_tc;
    logic          beat_ld, beat_dec, beat_tc;
    logic          gap_ld, gap_dec, gap_tc;
    logic          col_ld, col_dec, col_tc;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_idx;
    logic          is_pad;
    logic          row_end;
    logic [RW-1:0] row;
    logic          overrun;
    logic [FIFO_RD_LAT-1:0] valid_sr;

    sched_cnt #(.W(WW)) u_wait_cnt (
        .i_sclk(i_sclk), .i_rst(i_rst), .clr(i_vsync), .load(wait_ld),
        .load_val(WAIT_LD), .dec(wait_dec), .cnt(wait_cnt), .tc(wait_tc)
    );

    sched_cnt #(.W(BW)) u_beat_cnt (
        .i_sclk(i_sclk), .i_rst(i_rst), .clr(i_vsync), .load(beat_ld),
        .load_val(BEAT_LD), .dec(beat_dec), .cnt(beat_cnt), .tc(beat_tc)
    );

    sched_cnt #(.W(GW)) u_gap_cnt (
        .i_sclk(i_sclk), .i_rst(i_rst), .clr(i_vsync), .load(gap_ld),
        .load_val(GAP_LD), .dec(gap_dec), .cnt(gap_cnt), .tc(gap_tc)
    );

    sched_cnt #(.W(CW)) u_col_cnt (
        .i_sclk(i_sclk), .i_rst(i_rst), .clr(i_vsync), .load(col_ld),
        .load_val(COL_LD), .dec(col_dec), .cnt(col_cnt), .tc(col_tc)
    );

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // row_end depends only on registered state so o_row_done has no input path.
    always_comb begin
        state_nx = state;
        wait_ld  = 1'b0;
        wait_dec = 1'b0;
        beat_ld  = 1'b0;
        beat_dec = 1'b0;
        gap_ld   = 1'b0;
        gap_dec  = 1'b0;
        col_ld   = 1'b0;
        col_dec  = 1'b0;
        row_end  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_hsync) begin
                    col_ld = 1'b1;
                    if (PADWAIT > 0) begin
                        state_nx = ST_WAIT;
                        wait_ld  = 1'b1;
                    end else begin
                        state_nx = ST_SLOT;
                        beat_ld  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wait_dec = 1'b1;
                if (wait_tc) begin
                    state_nx = ST_SLOT;
                    beat_ld  = 1'b1;
                end
            end
            ST_SLOT: begin
                beat_dec = 1'b1;
                if (beat_tc) begin
                    if (GAP > 0) begin
                        state_nx = ST_GAP;
                        gap_ld   = 1'b1;
                    end else if (col_tc) begin
                        state_nx = ST_IDLE;
                        row_end  = 1'b1;
                    end else begin
                        col_dec = 1'b1;
                        beat_ld = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_tc) begin
                    if (col_tc) begin
                        state_nx = ST_IDLE;
                        row_end  = 1'b1;
                    end else begin
                        state_nx = ST_SLOT;
                        col_dec  = 1'b1;
                        beat_ld  = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (i_vsync)
            state_nx = ST_IDLE;
    end

    assign col_idx = COL_LD - col_cnt;
    assign is_pad  = (col_idx < PAD_LO) || (col_idx >= PAD_HI);

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            row      <= '0;
            overrun  <= 1'b0;
            valid_sr <= '0;
            o_vsync  <= 1'b0;
        end else begin
            valid_sr <= FIFO_RD_LAT'({valid_sr, o_rdreq});
            o_vsync  <= i_vsync;
            if (i_vsync) begin
                row     <= '0;
                overrun <= 1'b0;
            end else begin
                if (row_end)
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                if (i_hsync && (state != ST_IDLE))
                    overrun <= 1'b1;
            end
        end
    end

    assign o_rdreq      = (state == ST_SLOT) && !is_pad;
    assign o_reuse      = (state == ST_SLOT) && is_pad;
    assign o_hsync      = (state == ST_SLOT) && (col_cnt == COL_LD) && (beat_cnt == BEAT_LD);
    assign o_valid      = valid_sr[FIFO_RD_LAT-1];
    assign o_row_done   = row_end;
    assign o_frame_done = row_end && (row == ROW_LAST);
    assign o_row        = row;
    assign o_busy       = (state != ST_IDLE);
    assign o_overrun    = overrun;

endmodule

// File: tb/tb_conv_row_sched.sv
// Bench for conv_row_sched: table-driven row checks, directed corner sequences,
// and randomized hsync/vsync against an arithmetic per-cycle reference model.
module tb_conv_row_sched;

    localparam int SZ   = 4;
    localparam int CH   = 2;
    localparam int PW   = 3;
    localparam int GP   = 1;
    localparam int PD   = 1;
    localparam int NCOL = SZ + 2 * PD;

    typedef struct packed {
        logic       hs;
        logic       rd;
        logic       va;
        logic       ru;
        logic       vs;
        logic       rdn;
        logic       fd;
        logic       busy;
        logic       ovr;
        logic [1:0] row;
    } obs_t;

    typedef struct {
        int start;
        int row;
        bit ovr;
        bit prd;
        bit pvs;
    } mdl_t;

    typedef struct {
        bit         h;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic h_a = 1'b0, v_a = 1'b0, h_b = 1'b0, v_b = 1'b0;

    logic a_rd, a_va, a_ru, a_hs, a_vs, a_rdn, a_fd, a_busy, a_ovr;
    logic b_rd, b_va, b_ru, b_hs, b_vs, b_rdn, b_fd, b_busy, b_ovr;
    logic [1:0] a_row, b_row;
    obs_t oa, ob;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    mdl_t ma, mb;
    vec_t tab[24];

    always #5 clk = ~clk;

    conv_row_sched #(.SIZE(SZ), .CHANNEL(CH), .PADWAIT(PW), .GAP(GP), .PAD(PD)) dut (
        .i_sclk(clk), .i_rst(rst), .i_vsync(v_a), .i_hsync(h_a),
        .o_rdreq(a_rd), .o_valid(a_va), .o_reuse(a_ru), .o_hsync(a_hs),
        .o_vsync(a_vs), .o_row_done(a_rdn), .o_frame_done(a_fd),
        .o_row(a_row), .o_busy(a_busy), .o_overrun(a_ovr)
    );

    conv_row_sched #(.SIZE(SZ), .CHANNEL(CH), .PADWAIT(0), .GAP(0), .PAD(PD)) dut0 (
        .i_sclk(clk), .i_rst(rst), .i_vsync(v_b), .i_hsync(h_b),
        .o_rdreq(b_rd), .o_valid(b_va), .o_reuse(b_ru), .o_hsync(b_hs),
        .o_vsync(b_vs), .o_row_done(b_rdn), .o_frame_done(b_fd),
        .o_row(b_row), .o_busy(b_busy), .o_overrun(b_ovr)
    );

    assign oa = '{hs: a_hs, rd: a_rd, va: a_va, ru: a_ru, vs: a_vs, rdn: a_rdn,
                  fd: a_fd, busy: a_busy, ovr: a_ovr, row: a_row};
    assign ob = '{hs: b_hs, rd: b_rd, va: b_va, ru: b_ru, vs: b_vs, rdn: b_rdn,
                  fd: b_fd, busy: b_busy, ovr: b_ovr, row: b_row};

    // Reference: a row accepted at cycle t has its first slot beat at t+pw+1 and
    // lasts NCOL*(CH+gp) cycles; everything else follows by division/modulo.
    function automatic obs_t mdl_out(mdl_t m, int k, int gp);
        obs_t o;
        int   len, per, rel, col;
        o     = '0;
        per   = CH + gp;
        len   = NCOL * per;
        o.vs  = m.pvs;
        o.va  = m.prd;
        o.ovr = m.ovr;
        o.row = 2'(m.row);
        if (m.start >= 0) begin
            rel    = k - m.start;
            o.busy = 1'b1;
            if (rel >= 0 && rel < len && (rel % per) < CH) begin
                col  = rel / per;
                o.ru = (col < PD) || (col >= SZ + PD);
                o.rd = !o.ru;
                o.hs = (rel == 0);
            end
            o.rdn = (rel == len - 1);
            o.fd  = o.rdn && (m.row == SZ - 1);
        end
        return o;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, obs_t o, int k, bit h, bit v, int pw);
        mdl_t n;
        n     = m;
        n.prd = o.rd;
        n.pvs = v;
        if (v) begin
            n.start = -1;
            n.row   = 0;
            n.ovr   = 1'b0;
        end else begin
            if (o.rdn) begin
                n.row   = (m.row + 1) % SZ;
                n.start = -1;
            end
            if (h) begin
                if (o.busy) n.ovr = 1'b1;
                else        n.start = k + pw + 1;
            end
        end
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.start = -1;
        m.row   = 0;
        m.ovr   = 1'b0;
        m.prd   = 1'b0;
        m.pvs   = 1'b0;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t ea, eb;
        if (rst) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ea = mdl_out(ma, cyc, GP);
            chk("model_a", 16'(oa), 16'(ea));
            ma = mdl_step(ma, ea, cyc, h_a, v_a, PW);
            eb = mdl_out(mb, cyc, 0);
            chk("model_b", 16'(ob), 16'(eb));
            mb = mdl_step(mb, eb, cyc, h_b, v_b, 0);
        end
        cyc++;
    end

    task automatic tick(input bit ha, input bit va, input bit hb, input bit vb);
        @(posedge clk);
        #1;
        h_a = ha; v_a = va; h_b = hb; v_b = vb;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_frame();
        tick(0, 1, 0, 1);
        tick(0, 0, 0, 0);
    endtask

    function automatic bit in_q(input int q[$], input int k);
        foreach (q[i]) if (q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    // One row from the table; h2>=0 adds a second hsync that must be ignored.
    task automatic run_table(input int h2);
        for (int k = 0; k < 24; k++) begin
            tick(tab[k].h || (k == h2), 0, 0, 0);
            chk($sformatf("row_k%0d", k), 16'({a_hs, a_rd, a_va, a_ru, a_rdn, a_busy}),
                16'(tab[k].exp));
            chk("overrun", 16'(a_ovr), 16'(h2 >= 0 && k > h2));
        end
        chk("row_after", 16'(a_row), 16'd1);
    endtask

    initial begin
        int rd_q[$] = '{7, 8, 10, 11, 13, 14, 16, 17};
        int va_q[$] = '{8, 9, 11, 12, 14, 15, 17, 18};
        int ru_q[$] = '{4, 5, 19, 20};
        int fd_cnt, rdn_cnt;
        bit found;

        for (int k = 0; k < 24; k++) begin
            tab[k].h   = (k == 0);
            tab[k].exp = {k == 4, in_q(rd_q, k), in_q(va_q, k), in_q(ru_q, k),
                          k == 21, k >= 1 && k <= 21};
        end

        #3;
        chk("reset_a", 16'(oa), 16'd0);
        chk("reset_b", 16'(ob), 16'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // Single row timing.
        clear_frame();
        run_table(-1);

        // Four rows: o_row wraps and o_frame_done only on the last.
        clear_frame();
        fd_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            tick(1, 0, 0, 0);
            found = 1'b0;
            for (int n = 0; n < 30 && !found; n++) begin
                tick(0, 0, 0, 0);
                if (a_fd) fd_cnt++;
                if (a_rdn) begin
                    found = 1'b1;
                    chk("frame_done_at_row_done", 16'(a_fd), 16'(r == 3));
                end
            end
            chk("row_done_seen", 16'(found), 16'd1);
            tick(0, 0, 0, 0);
            chk("row_count", 16'(a_row), 16'((r + 1) % 4));
        end
        chk("frame_done_count", 16'(fd_cnt), 16'd1);

        // Overrun: second hsync mid-row ignored.
        clear_frame();
        run_table(10);

        // Mid-row vsync abort.
        clear_frame();
        rdn_cnt = 0;
        for (int k = 0; k < 31; k++) begin
            tick(k == 0 || k == 5, k == 12, 0, 0);
            if (k == 12) chk("ovr_before_vsync", 16'(a_ovr), 16'd1);
            if (k == 13) begin
                chk("abort_rdreq", 16'(a_rd), 16'd0);
                chk("abort_busy", 16'(a_busy), 16'd0);
                chk("abort_valid", 16'(a_va), 16'(tab[12].exp[4]));
                chk("abort_ovr", 16'(a_ovr), 16'd0);
            end
            if (k > 12 && a_rdn) rdn_cnt++;
        end
        chk("abort_no_row_done", 16'(rdn_cnt), 16'd0);
        chk("abort_row", 16'(a_row), 16'd0);

        // PADWAIT=0, GAP=0 instance: 12 contiguous beats.
        clear_frame();
        for (int k = 0; k < 15; k++) begin
            tick(0, 0, k == 0, 0);
            chk($sformatf("dense_k%0d", k), 16'({b_hs, b_rd | b_ru, b_ru, b_rdn, b_busy}),
                16'({k == 1, k >= 1 && k <= 12, k == 1 || k == 2 || k == 11 || k == 12,
                     k == 12, k >= 1 && k <= 12}));
        end

        // Asynchronous reset mid-SLOT, then a normal row.
        clear_frame();
        for (int k = 0; k < 9; k++) tick(k == 0, 0, 0, 0);
        chk("pre_reset_rd", 16'(a_rd), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_a", 16'(oa), 16'd0);
        chk("async_reset_b", 16'(ob), 16'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        tick(0, 0, 0, 0);
        run_table(-1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++)
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
        tick(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
